// File: rtl/prog_fetch_if.sv
// Bundle of the prefetch, local-RAM and external-bus signals of the program fetch port.
// The slave modport is the fetch port; the master modport is its environment.
interface prog_fetch_if #(
  parameter int DATA_W = 32
);
  logic              progreq;
  logic [21:0]       progaddr;
  logic              pabort;
  logic              progack;
  logic [DATA_W-1:0] prog_data;
  logic              lram_busy;
  logic              lram_rd;
  logic [9:0]        lram_addr;
  logic [DATA_W-1:0] lram_dout;
  logic              ext_req;
  logic [21:0]       ext_addr;
  logic              ext_ack;
  logic [DATA_W-1:0] ext_data;

  modport slave (
    input  progreq, progaddr, pabort, lram_busy, lram_dout, ext_ack, ext_data,
    output progack, prog_data, lram_rd, lram_addr, ext_req, ext_addr
  );

  modport master (
    output progreq, progaddr, pabort, lram_busy, lram_dout, ext_ack, ext_data,
    input  progack, prog_data, lram_rd, lram_addr, ext_req, ext_addr
  );
endinterface

// File: rtl/prog_fetch_port.sv
// Program fetch port: serves prefetch long-word requests from local RAM (F03000-F03FFF)
// or the external bus, with abort draining so the bus handshake is never cut short.
module prog_fetch_port #(
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  prog_fetch_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LRD, XREQ, DRAIN} state_t;

  state_t            state_p1, state_nxt;
  logic              local_hit;
  logic              take_local, take_ext;
  logic              ack;
  logic [DATA_W-1:0] ack_data;
  logic [9:0]        lram_addr_p1;
  logic [21:0]       ext_addr_p1;
  logic [DATA_W-1:0] prog_data_p1;

  assign local_hit = (bus.progaddr[21:10] == 12'hF03);

  // reset_n gates acceptance so no RAM read is issued while reset is held
  always_comb begin
    state_nxt  = state_p1;
    take_local = 1'b0;
    take_ext   = 1'b0;
    ack        = 1'b0;
    ack_data   = prog_data_p1;
    case (state_p1)
      IDLE: begin
        if (reset_n && bus.progreq && !bus.pabort) begin
          if (!local_hit) begin
            take_ext  = 1'b1;
            state_nxt = XREQ;
          end else if (!bus.lram_busy) begin
            take_local = 1'b1;
            state_nxt  = LRD;
          end
        end
      end
      LRD: begin
        state_nxt = IDLE;
        if (!bus.pabort) begin
          ack      = 1'b1;
          ack_data = bus.lram_dout;
        end
      end
      XREQ: begin
        if (bus.ext_ack) begin
          state_nxt = IDLE;
          if (!bus.pabort) begin
            ack      = 1'b1;
            ack_data = bus.ext_data;
          end
        end else if (bus.pabort) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.ext_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state / address / data hold registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_p1     <= IDLE;
      lram_addr_p1 <= '0;
      ext_addr_p1  <= '0;
      prog_data_p1 <= '0;
    end else begin
      state_p1 <= state_nxt;
      if (take_local) lram_addr_p1 <= bus.progaddr[9:0];
      if (take_ext)   ext_addr_p1  <= bus.progaddr;
      if (ack)        prog_data_p1 <= ack_data;
    end
  end

  assign bus.progack   = ack;
  assign bus.prog_data = ack_data;
  assign bus.lram_rd   = take_local;
  assign bus.lram_addr = take_local ? bus.progaddr[9:0] : lram_addr_p1;
  assign bus.ext_req   = (state_p1 == XREQ) || (state_p1 == DRAIN);
  assign bus.ext_addr  = ext_addr_p1;

endmodule
